// File: rtl/led_row_scanner.sv
// led_row_scanner
// Time-multiplexed row scanner for an 8x8 LED matrix. Holds the displayed
// frame (active) and a shadow frame loaded through a valid/ready handshake.
// Each row gets BLANK_CYCLES of blanking followed by DWELL_CYCLES of drive.
// The shadow frame is promoted to active only at the row 7 -> row 0 wrap.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   ena          scan enable; low forces IDLE
//   cells        next frame, bit r*8+c = row r, column c
//   cells_valid  cells holds a new frame
//   cells_ready  shadow buffer empty (straight from the shadow_full flop)
//   row_addr     row index to the 3-to-8 decoder
//   row_ena      decoder enable, high only while a row is driven
//   cols         column data for row_addr, zero while row_ena is low
//   frame_done   one-cycle pulse in the first BLANK cycle after a frame wrap
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | scan stopped, outputs blanked, row held at 0
// S_BLANK | row_addr set up, decoder disabled (anti-ghost)
// S_DRIVE | decoder enabled, cols show the current row

module led_row_scanner #(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [63:0] cells,
   input  logic        cells_valid,
   output logic        cells_ready,
   output logic [2:0]  row_addr,
   output logic        row_ena,
   output logic [7:0]  cols,
   output logic        frame_done
);

   localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     row_q, row_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [63:0]    active_q, active_d;
   logic [63:0]    shadow_q, shadow_d;
   logic           full_q, full_d;
   logic           wrap;

   logic [2:0]     row_addr_q, row_addr_d;
   logic           row_ena_q, row_ena_d;
   logic [7:0]     cols_q, cols_d;
   logic           frame_done_q, frame_done_d;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      shadow_d = shadow_q;
      full_d   = full_q;
      wrap     = 1'b0;

      // Load and transfer are mutually exclusive: load needs full_q=0,
      // transfer needs full_q=1.
      if (cells_valid && !full_q) begin
         shadow_d = cells;
         full_d   = 1'b1;
      end

      if (!ena) begin
         state_d = S_IDLE;
         row_d   = 3'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               row_d   = 3'd0;
               cnt_d   = '0;
            end
            S_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_DRIVE: begin
               if (cnt_q == DWELL_LAST) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  row_d   = row_q + 3'd1;
                  if (row_q == 3'd7) begin
                     wrap = 1'b1;
                     if (full_q) begin
                        active_d = shadow_q;
                        full_d   = 1'b0;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               row_d   = 3'd0;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are computed from next state so they come straight off flops
      // and change on the same edge as the state.
      row_addr_d   = row_d;
      row_ena_d    = (state_d == S_DRIVE);
      cols_d       = row_ena_d ? active_d[{row_d, 3'b000} +: 8] : 8'h00;
      frame_done_d = wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         row_q        <= 3'd0;
         cnt_q        <= '0;
         active_q     <= '0;
         shadow_q     <= '0;
         full_q       <= 1'b0;
         row_addr_q   <= 3'd0;
         row_ena_q    <= 1'b0;
         cols_q       <= 8'h00;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         full_q       <= full_d;
         row_addr_q   <= row_addr_d;
         row_ena_q    <= row_ena_d;
         cols_q       <= cols_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign cells_ready = !full_q;
   assign row_addr    = row_addr_q;
   assign row_ena     = row_ena_q;
   assign cols        = cols_q;
   assign frame_done  = frame_done_q;

endmodule
